// File: rtl/exception_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// exception_sequencer_pkg
// Shared definitions for the exception sequencer and its neighbours: the
// control unit and the vector-address mux use the same state encodings,
// cause codes, ExcCode values and default vector-table base.
//
// Contents:
//   ST_*            FSM state encodings (IDLE, CAPTURE, WAIT, LOAD, DONE)
//   CAUSE_*         2-bit latched cause codes
//   EXCCODE_*       MIPS-style ExcCode values for the optional Cause register
//   *_DEFAULT       default parameter values for the sequencer
//   prio_cause()    fixed-priority cause selection (opcode > ovf > div0)
//   cause_reg_value() builds the 32-bit Cause register image from a cause
// ---------------------------------------------------------------------------
package exception_sequencer_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [1:0] CAUSE_OPCODE = 2'b00;
    localparam logic [1:0] CAUSE_OVF    = 2'b01;
    localparam logic [1:0] CAUSE_DIV0   = 2'b10;

    localparam logic [4:0] EXCCODE_OPCODE = 5'd10;
    localparam logic [4:0] EXCCODE_OVF    = 5'd12;
    localparam logic [4:0] EXCCODE_DIV0   = 5'd15;

    localparam logic [31:0] VEC_BASE_DEFAULT   = 32'd253;
    localparam logic [31:0] EPC_OFFSET_DEFAULT = 32'd4;
    localparam int          MEM_LAT_DEFAULT    = 2;

    // Width of the memory-wait counter; covers latencies 1..15.
    localparam int WAIT_CNT_W = 4;

    // Fixed-priority selection. The caller only uses the result when at
    // least one flag is set, so "neither opcode nor ovf" means div0.
    function automatic logic [1:0] prio_cause(input logic exc_opcode,
                                              input logic exc_ovf);
        logic [1:0] c;
        if (exc_opcode) begin
            c = CAUSE_OPCODE;
        end else if (exc_ovf) begin
            c = CAUSE_OVF;
        end else begin
            c = CAUSE_DIV0;
        end
        return c;
    endfunction

    // MIPS-style Cause register image: ExcCode in bits [6:2], rest zero.
    function automatic logic [31:0] cause_reg_value(input logic [1:0] c);
        logic [4:0] code;
        case (c)
            CAUSE_OPCODE: code = EXCCODE_OPCODE;
            CAUSE_OVF:    code = EXCCODE_OVF;
            CAUSE_DIV0:   code = EXCCODE_DIV0;
            default:      code = 5'd0;
        endcase
        return {25'd0, code, 2'b00};
    endfunction

endpackage

// File: rtl/exception_sequencer_wait_counter.sv
// ---------------------------------------------------------------------------
// exception_sequencer_wait_counter
// Load/decrement counter used to sit out a fixed memory read latency. Load
// it with the latency on the cycle before the wait state, decrement during
// the wait state; 'done' is high on the last counted cycle so the caller
// can leave the wait state on that edge. Reusable by other memory-wait
// states in the control unit.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high; clears the count
//   load      in   1   load load_val (has priority over dec)
//   load_val  in   W   number of cycles to count
//   dec       in   1   count down by one (saturates at zero)
//   done      out  1   count == 1, i.e. final cycle of the wait
// ---------------------------------------------------------------------------
module exception_sequencer_wait_counter
    import exception_sequencer_pkg::*;
#(
    parameter int W = WAIT_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Count register; saturating so a stray dec at zero cannot wrap to max.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == CNT_ONE);

endmodule

// File: rtl/exception_sequencer.sv
// ---------------------------------------------------------------------------
// exception_sequencer
// Redirects the PC to an exception handler. Takes the raw exception flags
// from the datapath, latches one cause by priority (opcode > ovf > div0),
// reads the handler byte from the vector table at VEC_BASE+cause, writes
// EPC (pc_current - EPC_OFFSET) and then loads PC with the zero-extended
// handler byte. While busy it owns the PC/EPC write strobes.
//
// Timeline (detection edge = E0, MEM_LAT = L):
//   cycle 1        CAPTURE  mem_rd=1, vec_addr valid, epc_wr=1
//   cycles 2..L+1  WAIT     mem_rd held, vec_addr stable
//   cycle L+2      LOAD     pc_out valid, pc_wr=1, mem_rd=0
//   cycle L+3      DONE     busy still 1
//   cycle L+4      IDLE     busy=0, flags sampled again
//
// Parameters:
//   VEC_BASE    vector-table address of cause 0
//   MEM_LAT     cycles from mem_rd to valid mem_data_in (1..15)
//   EPC_OFFSET  subtracted from pc_current to form EPC
//
// Ports:
//   clk, reset   clock / synchronous active-high reset
//   exc_opcode, exc_ovf, exc_div0   level flags, sampled in IDLE only
//   pc_current   current (already incremented) PC
//   mem_data_in  vector-table read data, handler address in [7:0]
//   vec_addr, mem_rd          vector-table read request
//   epc_out, epc_wr           EPC write (one-cycle strobe)
//   pc_out, pc_wr             PC write (one-cycle strobe)
//   busy                      stall request to the main control unit
//   cause                     latched cause (00 opcode, 01 ovf, 10 div0)
//   cause_reg                 MIPS Cause register, only with EXC_CAUSE_REG_EN
//
// Build option: define EXC_CAUSE_REG_EN to add the 32-bit cause_reg output.
// ---------------------------------------------------------------------------
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter int          MEM_LAT    = MEM_LAT_DEFAULT,
    parameter logic [31:0] EPC_OFFSET = EPC_OFFSET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] pc_current,
    input  logic [31:0] mem_data_in,
    output logic [31:0] vec_addr,
    output logic        mem_rd,
    output logic [31:0] epc_out,
    output logic        epc_wr,
    output logic [31:0] pc_out,
    output logic        pc_wr,
    output logic        busy,
    output logic [1:0]  cause
`ifdef EXC_CAUSE_REG_EN
    ,
    output logic [31:0] cause_reg
`endif
);

    localparam logic [WAIT_CNT_W-1:0] LAT_LOAD = WAIT_CNT_W'(MEM_LAT);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        flag_any_s;
    logic [1:0]  cause_nxt_s;
    logic        cnt_load_s;
    logic        cnt_dec_s;
    logic        cnt_done_s;

    logic [31:0] vec_addr_r;
    logic        mem_rd_r;
    logic [31:0] epc_out_r;
    logic        epc_wr_r;
    logic [31:0] pc_out_r;
    logic        pc_wr_r;
    logic        busy_r;
    logic [1:0]  cause_r;

    // Flag qualification and priority pick for the cause latched on detection.
    always_comb begin
        flag_any_s  = exc_opcode | exc_ovf | exc_div0;
        cause_nxt_s = prio_cause(exc_opcode, exc_ovf);
    end

    // Counter is loaded as CAPTURE exits and runs only while in WAIT.
    always_comb begin
        cnt_load_s = (state_r == ST_CAPTURE);
        cnt_dec_s  = (state_r == ST_WAIT);
    end

    exception_sequencer_wait_counter #(
        .W (WAIT_CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec_s),
        .done     (cnt_done_s)
    );

    // Next-state logic; flags only matter in IDLE so sequences never nest.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flag_any_s) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (cnt_done_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_LOAD: state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, updated on the edge that enters the state in
    // which they must be visible; a reset mid-sequence drops every strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_addr_r <= 32'd0;
            mem_rd_r   <= 1'b0;
            epc_out_r  <= 32'd0;
            epc_wr_r   <= 1'b0;
            pc_out_r   <= 32'd0;
            pc_wr_r    <= 1'b0;
            busy_r     <= 1'b0;
            cause_r    <= CAUSE_OPCODE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flag_any_s) begin
                        busy_r     <= 1'b1;
                        cause_r    <= cause_nxt_s;
                        epc_out_r  <= pc_current - EPC_OFFSET;
                        epc_wr_r   <= 1'b1;
                        mem_rd_r   <= 1'b1;
                        vec_addr_r <= VEC_BASE + {30'd0, cause_nxt_s};
                    end else begin
                        busy_r     <= 1'b0;
                        epc_wr_r   <= 1'b0;
                        mem_rd_r   <= 1'b0;
                        vec_addr_r <= 32'd0;
                    end
                end
                ST_CAPTURE: begin
                    epc_wr_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (cnt_done_s) begin
                        // Masking keeps only the handler byte (zero-extend).
                        pc_out_r   <= mem_data_in & 32'h0000_00FF;
                        pc_wr_r    <= 1'b1;
                        mem_rd_r   <= 1'b0;
                        vec_addr_r <= 32'd0;
                    end
                end
                ST_LOAD: begin
                    pc_wr_r <= 1'b0;
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r     <= 1'b0;
                    epc_wr_r   <= 1'b0;
                    pc_wr_r    <= 1'b0;
                    mem_rd_r   <= 1'b0;
                    vec_addr_r <= 32'd0;
                end
            endcase
        end
    end

    assign vec_addr = vec_addr_r;
    assign mem_rd   = mem_rd_r;
    assign epc_out  = epc_out_r;
    assign epc_wr   = epc_wr_r;
    assign pc_out   = pc_out_r;
    assign pc_wr    = pc_wr_r;
    assign busy     = busy_r;
    assign cause    = cause_r;

`ifdef EXC_CAUSE_REG_EN
    logic [31:0] cause_reg_r;

    // Cause register loads on the same edge that raises epc_wr; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_reg_r <= 32'd0;
        end else if ((state_r == ST_IDLE) && flag_any_s) begin
            cause_reg_r <= cause_reg_value(cause_nxt_s);
        end else begin
            cause_reg_r <= cause_reg_r;
        end
    end

    assign cause_reg = cause_reg_r;
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: two instances (MEM_LAT=2 and MEM_LAT=5)
// share clock and reset; a vector-table memory model answers each read only
// after the configured latency and returns junk before that.
module tb_exception_sequencer;

    localparam int WIN = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  flags = 3'b000;   // {opcode, ovf, div0}
    logic        sel = 1'b0;       // 0: unit a (lat 2), 1: unit b (lat 5)
    logic [31:0] pc_in = 32'd0;
    logic [31:0] mem_w [0:2];      // vector table words at 253..255
    logic [31:0] pc_hold [0:1];    // last pc_out each unit should hold
    logic [31:0] junk = 32'd0;

    int n_checks = 0;
    int n_fail = 0;

    logic        opc_a, ovf_a, div0_a, opc_b, ovf_b, div0_b;
    logic [31:0] mem_data_a, mem_data_b, vec_addr_a, vec_addr_b;
    logic [31:0] epc_out_a, epc_out_b, pc_out_a, pc_out_b;
    logic        mem_rd_a, mem_rd_b, epc_wr_a, epc_wr_b, pc_wr_a, pc_wr_b;
    logic        busy_a, busy_b;
    logic [1:0]  cause_a, cause_b;
`ifdef EXC_CAUSE_REG_EN
    logic [31:0] cause_reg_a, cause_reg_b;
`endif

    assign opc_a  = flags[2] & ~sel;
    assign ovf_a  = flags[1] & ~sel;
    assign div0_a = flags[0] & ~sel;
    assign opc_b  = flags[2] & sel;
    assign ovf_b  = flags[1] & sel;
    assign div0_b = flags[0] & sel;

    exception_sequencer #(.VEC_BASE(32'd253), .MEM_LAT(2), .EPC_OFFSET(32'd4)) dut_a (
        .clk(clk), .reset(reset), .exc_opcode(opc_a), .exc_ovf(ovf_a), .exc_div0(div0_a),
        .pc_current(pc_in), .mem_data_in(mem_data_a), .vec_addr(vec_addr_a), .mem_rd(mem_rd_a),
        .epc_out(epc_out_a), .epc_wr(epc_wr_a), .pc_out(pc_out_a), .pc_wr(pc_wr_a),
        .busy(busy_a), .cause(cause_a)
`ifdef EXC_CAUSE_REG_EN
        , .cause_reg(cause_reg_a)
`endif
    );

    exception_sequencer #(.VEC_BASE(32'd253), .MEM_LAT(5), .EPC_OFFSET(32'd4)) dut_b (
        .clk(clk), .reset(reset), .exc_opcode(opc_b), .exc_ovf(ovf_b), .exc_div0(div0_b),
        .pc_current(pc_in), .mem_data_in(mem_data_b), .vec_addr(vec_addr_b), .mem_rd(mem_rd_b),
        .epc_out(epc_out_b), .epc_wr(epc_wr_b), .pc_out(pc_out_b), .pc_wr(pc_wr_b),
        .busy(busy_b), .cause(cause_b)
`ifdef EXC_CAUSE_REG_EN
        , .cause_reg(cause_reg_b)
`endif
    );

    // Memory model: data valid once mem_rd has been high for 'lat' cycles.
    int rd_cnt_a = 0;
    int rd_cnt_b = 0;
    always @(posedge clk) begin
        rd_cnt_a <= mem_rd_a ? rd_cnt_a + 1 : 0;
        rd_cnt_b <= mem_rd_b ? rd_cnt_b + 1 : 0;
        junk     <= $urandom & 32'hFFFF_FF00;
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic en,
                                             input int cnt, input int lat, input logic [31:0] j);
        int idx;
        idx = int'(a) - 253;
        if (en && (cnt >= lat) && (idx >= 0) && (idx <= 2)) return mem_w[idx];
        return j;
    endfunction

    assign mem_data_a = mem_read(vec_addr_a, mem_rd_a, rd_cnt_a, 2, junk);
    assign mem_data_b = mem_read(vec_addr_b, mem_rd_b, rd_cnt_b, 5, junk);

    // Observed unit
    logic [31:0] o_vec, o_epc, o_pc;
    logic        o_rd, o_epc_wr, o_pc_wr, o_busy;
    logic [1:0]  o_cause;
    assign o_vec    = sel ? vec_addr_b : vec_addr_a;
    assign o_epc    = sel ? epc_out_b : epc_out_a;
    assign o_pc     = sel ? pc_out_b : pc_out_a;
    assign o_rd     = sel ? mem_rd_b : mem_rd_a;
    assign o_epc_wr = sel ? epc_wr_b : epc_wr_a;
    assign o_pc_wr  = sel ? pc_wr_b : pc_wr_a;
    assign o_busy   = sel ? busy_b : busy_a;
    assign o_cause  = sel ? cause_b : cause_a;

    // Per-cycle record of one sequence; cycle 1 follows the detection edge
    logic [31:0] r_vec [1:WIN];
    logic [31:0] r_epc [1:WIN];
    logic [31:0] r_pc  [1:WIN];
    logic        r_rd [1:WIN], r_epc_wr [1:WIN], r_pc_wr [1:WIN], r_busy [1:WIN];
    logic [1:0]  r_cause [1:WIN];
`ifdef EXC_CAUSE_REG_EN
    logic [31:0] r_creg [1:WIN];
`endif

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        if (busy_a || busy_b) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy_a=%0b busy_b=%0b, required 0", busy_a, busy_b);
        end
    endtask

    task automatic run_seq(input logic s, input logic [2:0] f, input logic [31:0] pc,
                           input int inj_k, input logic [2:0] inj_f, input logic hold);
        wait_idle();
        @(negedge clk);
        sel = s;
        flags = f;
        pc_in = pc;
        @(posedge clk);
        #1;
        if (!hold) begin
            flags = 3'b000;
            pc_in = $urandom;
        end
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            r_vec[k] = o_vec;  r_epc[k] = o_epc;  r_pc[k] = o_pc;  r_rd[k] = o_rd;
            r_epc_wr[k] = o_epc_wr;  r_pc_wr[k] = o_pc_wr;  r_busy[k] = o_busy;
            r_cause[k] = o_cause;
`ifdef EXC_CAUSE_REG_EN
            r_creg[k] = s ? cause_reg_b : cause_reg_a;
`endif
            if (k == inj_k) flags = inj_f;
            else if (!hold) flags = 3'b000;
        end
        flags = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({vec_addr_a, vec_addr_b, epc_out_a, epc_out_b, pc_out_a, pc_out_b} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h %h %h, required all 0",
                     vec_addr_a, vec_addr_b, epc_out_a, epc_out_b, pc_out_a, pc_out_b);
        end
        n_checks++;
        if ({mem_rd_a, mem_rd_b, epc_wr_a, epc_wr_b, pc_wr_a, pc_wr_b, busy_a, busy_b,
             cause_a, cause_b} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rd=%b%b epc_wr=%b%b pc_wr=%b%b busy=%b%b cause=%b %b, required 0",
                     mem_rd_a, mem_rd_b, epc_wr_a, epc_wr_b, pc_wr_a, pc_wr_b, busy_a, busy_b,
                     cause_a, cause_b);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_a, busy_b, mem_rd_a, mem_rd_b} !== 4'd0 || vec_addr_a !== 32'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b%b rd=%b%b vec=%h, required 0",
                     busy_a, busy_b, mem_rd_a, mem_rd_b, vec_addr_a);
        end
        pc_hold[0] = 32'd0;
        pc_hold[1] = 32'd0;
    endtask

    task automatic test_spec_example();
        mem_w[0] = 32'h1234_5688;  mem_w[1] = 32'h0000_0011;  mem_w[2] = 32'hABCD_EFFF;
        run_seq(1'b0, 3'b100, 32'h40, 0, 3'b000, 1'b0);
        n_checks++;
        if (r_vec[1] !== 32'd253 || r_rd[1] !== 1'b1) begin
            n_fail++; $display("FAIL ex_vec: got %0d rd=%b, required 253 rd=1", r_vec[1], r_rd[1]);
        end
        n_checks++;
        if (r_epc[1] !== 32'h3C || r_epc_wr[1] !== 1'b1) begin
            n_fail++; $display("FAIL ex_epc: got %h wr=%b, required 3c wr=1", r_epc[1], r_epc_wr[1]);
        end
        n_checks++;
        if (r_pc[4] !== 32'h88 || r_pc_wr[4] !== 1'b1 || r_pc_wr[3] !== 1'b0) begin
            n_fail++; $display("FAIL ex_pc_c4: got %h wr4=%b wr3=%b, required 88 1 0",
                               r_pc[4], r_pc_wr[4], r_pc_wr[3]);
        end
        n_checks++;
        if (r_cause[1] !== 2'b00) begin
            n_fail++; $display("FAIL ex_cause: got %b, required 00", r_cause[1]);
        end
        run_seq(1'b1, 3'b001, 32'h100, 0, 3'b000, 1'b0);
        n_checks++;
        if (r_pc[7] !== 32'hFF || r_pc_wr[7] !== 1'b1 || r_pc_wr[6] !== 1'b0) begin
            n_fail++; $display("FAIL ex_div0_lat5: got %h wr7=%b wr6=%b, required ff 1 0",
                               r_pc[7], r_pc_wr[7], r_pc_wr[6]);
        end
`ifdef EXC_CAUSE_REG_EN
        n_checks++;
        if (r_creg[1] !== 32'h3C) begin
            n_fail++; $display("FAIL ex_cause_reg: got %h, required 3c", r_creg[1]);
        end
`endif
        pc_hold[0] = 32'h88;
        pc_hold[1] = 32'hFF;
    endtask

    task automatic test_sequences();
        logic        s;
        logic [2:0]  f;
        logic [1:0]  c;
        logic [31:0] pc, tmp, e_vec, e_epc, e_pc, old_pc;
        int          lat;
        string       nm;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 3; i++) begin
                tmp = $urandom;
                if (tmp[7:0] == 8'h00) tmp[7:0] = 8'h01;
                mem_w[i] = tmp;
            end
            nm = "random";
            s = 1'($urandom_range(1, 0));
            f = 3'($urandom_range(7, 1));
            pc = $urandom;
            case (t)
                0: begin s = 1'b0; f = 3'b011; pc = 32'h1000; nm = "ovf_div0"; end
                1: begin s = 1'b0; f = 3'b110; pc = 32'h2004; nm = "opcode_ovf"; end
                2: begin s = 1'b1; f = 3'b111; pc = 32'hFFFF_FFF0; nm = "all_flags"; end
                3: begin s = 1'b0; f = 3'b001; pc = 32'h0; nm = "pc_wrap"; end
                4: begin s = 1'b1; f = 3'b010; pc = 32'h3; nm = "ovf_lat5"; end
                default: nm = "random";
            endcase
            // Reference model from the priority and timing rules
            if (f[2]) c = 2'd0;
            else if (f[1]) c = 2'd1;
            else c = 2'd2;
            lat = s ? 5 : 2;
            e_vec = 32'd253 + 32'(c);
            e_epc = pc - 32'd4;
            e_pc = {24'd0, mem_w[c][7:0]};
            old_pc = pc_hold[s];
            run_seq(s, f, pc, 0, 3'b000, 1'b0);
            pc_hold[s] = e_pc;
            for (int k = 1; k <= WIN; k++) begin
                n_checks++;
                if (r_busy[k] !== (k <= lat + 3) || r_rd[k] !== (k <= lat + 1)) begin
                    n_fail++; $display("FAIL %s t=%0d k=%0d busy/rd: got %b/%b, required %b/%b", nm, t, k,
                                       r_busy[k], r_rd[k], (k <= lat + 3), (k <= lat + 1));
                end
                n_checks++;
                if (r_epc_wr[k] !== (k == 1) || r_pc_wr[k] !== (k == lat + 2)) begin
                    n_fail++; $display("FAIL %s t=%0d k=%0d epc_wr/pc_wr: got %b/%b, required %b/%b", nm, t, k,
                                       r_epc_wr[k], r_pc_wr[k], (k == 1), (k == lat + 2));
                end
                n_checks++;
                if (r_cause[k] !== c || r_epc[k] !== e_epc) begin
                    n_fail++; $display("FAIL %s t=%0d k=%0d cause/epc: got %b/%h, required %b/%h", nm, t, k,
                                       r_cause[k], r_epc[k], c, e_epc);
                end
                n_checks++;
                if (r_pc[k] !== ((k >= lat + 2) ? e_pc : old_pc)) begin
                    n_fail++; $display("FAIL %s t=%0d k=%0d pc_out: got %h, required %h", nm, t, k,
                                       r_pc[k], (k >= lat + 2) ? e_pc : old_pc);
                end
                if (k <= lat + 1 || k >= lat + 4) begin
                    n_checks++;
                    if (r_vec[k] !== ((k <= lat + 1) ? e_vec : 32'd0)) begin
                        n_fail++; $display("FAIL %s t=%0d k=%0d vec_addr: got %0d, required %0d", nm, t, k,
                                           r_vec[k], (k <= lat + 1) ? e_vec : 32'd0);
                    end
                end
`ifdef EXC_CAUSE_REG_EN
                n_checks++;
                if (r_creg[k] !== ({25'd0, (c == 2'd0) ? 5'd10 : (c == 2'd1) ? 5'd12 : 5'd15, 2'b00})) begin
                    n_fail++; $display("FAIL %s t=%0d k=%0d cause_reg: got %h", nm, t, k, r_creg[k]);
                end
`endif
            end
        end
    endtask

    task automatic test_ignore_in_wait();
        int n_epc, n_pc;
        n_epc = 0;
        n_pc = 0;
        mem_w[1] = 32'h7777_7742;
        run_seq(1'b1, 3'b010, 32'h500, 3, 3'b100, 1'b0);
        for (int k = 1; k <= WIN; k++) begin
            n_epc += int'(r_epc_wr[k]);
            n_pc += int'(r_pc_wr[k]);
            n_checks++;
            if (r_cause[k] !== 2'b01 || (k <= 6 && r_vec[k] !== 32'd254)) begin
                n_fail++; $display("FAIL ignore_cause k=%0d: got cause %b vec %0d, required 01 254",
                                   k, r_cause[k], r_vec[k]);
            end
        end
        n_checks++;
        if (n_epc != 1 || n_pc != 1 || r_pc[7] !== 32'h42) begin
            n_fail++; $display("FAIL ignore_pulses: epc_wr=%0d pc_wr=%0d pc=%h, required 1 1 42",
                               n_epc, n_pc, r_pc[7]);
        end
        pc_hold[1] = 32'h42;
    endtask

    task automatic test_back_to_back();
        int n_pc;
        n_pc = 0;
        mem_w[2] = 32'h0000_0033;
        run_seq(1'b0, 3'b001, 32'h900, 0, 3'b000, 1'b1);
        for (int k = 1; k <= 12; k++) n_pc += int'(r_pc_wr[k]);
        n_checks++;
        if (r_epc_wr[1] !== 1'b1 || r_pc_wr[4] !== 1'b1 || r_busy[6] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: epc_wr1=%b pc_wr4=%b busy6=%b, required 1 1 0",
                               r_epc_wr[1], r_pc_wr[4], r_busy[6]);
        end
        n_checks++;
        if (r_busy[7] !== 1'b1 || r_epc_wr[7] !== 1'b1 || r_pc_wr[10] !== 1'b1 || r_epc[7] !== 32'h8FC) begin
            n_fail++; $display("FAIL b2b_second: busy7=%b epc_wr7=%b pc_wr10=%b epc=%h, required 1 1 1 8fc",
                               r_busy[7], r_epc_wr[7], r_pc_wr[10], r_epc[7]);
        end
        n_checks++;
        if (n_pc != 2 || r_pc[10] !== 32'h33 || r_cause[7] !== 2'b10) begin
            n_fail++; $display("FAIL b2b_count: pc_wr=%0d pc=%h cause=%b, required 2 33 10",
                               n_pc, r_pc[10], r_cause[7]);
        end
        pc_hold[0] = 32'h33;
    endtask

    task automatic test_reset_mid();
        int n_pulse;
        n_pulse = 0;
        wait_idle();
        @(negedge clk);
        sel = 1'b1;
        flags = 3'b001;
        @(posedge clk);
        #1;
        flags = 3'b000;
        @(negedge clk);          // cycle 1: CAPTURE
        @(negedge clk);          // cycle 2: WAIT
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy_b, mem_rd_b, epc_wr_b, pc_wr_b} !== 4'd0 || pc_out_b !== 32'd0 || cause_b !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid: busy=%b rd=%b epc_wr=%b pc_wr=%b pc=%h cause=%b, required 0",
                               busy_b, mem_rd_b, epc_wr_b, pc_wr_b, pc_out_b, cause_b);
        end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_pulse += int'(pc_wr_b) + int'(epc_wr_b) + int'(busy_b);
        end
        n_checks++;
        if (n_pulse != 0) begin
            n_fail++; $display("FAIL reset_mid_after: %0d strobe/busy cycles, required 0", n_pulse);
        end
        pc_hold[0] = 32'd0;
        pc_hold[1] = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mem_w[i] = 32'd1;
        pc_hold[0] = 32'd0;
        pc_hold[1] = 32'd0;
        test_reset();
        test_spec_example();
        test_sequences();
        test_ignore_in_wait();
        test_back_to_back();
        test_reset_mid();
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
